commit_rat_ctrl: RTL
====================

// Module: commit_rat_ctrl
// PURPOSE
// Commit-side driver of the RAT commit/release/restore interface. Takes retiring ROB head entries and issues
// commit + release of physical mappings. On a pipeline flush it undoes speculative renames, youngest first,
// by walking the ROB (default) or by a single-cycle committed-snapshot restore (optional).
// PARAMETERS
// COMMIT_WIDTH       `COMMIT_WIDTH       retire lanes per cycle
// PHY_REG_NUM        `PHY_REG_NUM        physical registers
// PHY_REG_ID_WIDTH   `PHY_REG_ID_WIDTH   physical register id width
// ARCH_REG_NUM       `ARCH_REG_NUM       architectural registers, x0 never mapped
// PORTS
// clk                            in   1                 clock
// rst                            in   1                 synchronous active-high reset
// rob_commit_valid               in   COMMIT_WIDTH      lane i retiring, lanes in order
// rob_commit_has_rd              in   COMMIT_WIDTH      lane writes rd != x0
// rob_commit_new_phy_id[i]       in   PHY_REG_ID_WIDTH  phy id allocated to lane i
// rob_commit_old_phy_id[i]       in   PHY_REG_ID_WIDTH  phy id previously mapped to rd
// commit_rob_ready               out  1                 lanes accepted this cycle
// flush_req                      in   1                 flush pulse
// rob_walk_valid/has_rd/last     in   1 each            walk entry (youngest first), rd flag, final entry
// rob_walk_new_phy_id/old_phy_id in   PHY_REG_ID_WIDTH  walk entry mapping
// commit_rob_walk_ready          out  1                 walk entry consumed
// flush_done                     out  1                 one-cycle pulse, rename may resume
// commit_rat_commit_phy_id[i]    out  PHY_REG_ID_WIDTH  phy id to mark committed
// commit_rat_commit_phy_id_valid out  COMMIT_WIDTH      per-lane valid
// commit_rat_commit_map          out  1                 commit strobe
// commit_rat_release_phy_id[i]   out  PHY_REG_ID_WIDTH  phy id to free
// commit_rat_release_phy_id_valid out COMMIT_WIDTH      per-lane valid
// commit_rat_release_map         out  1                 release strobe
// commit_rat_restore_new/old_phy_id out PHY_REG_ID_WIDTH walk undo: unmap new, re-expose old
// commit_rat_restore_map         out  1                 restore strobe
// commit_rat_map_table_valid/visible out PHY_REG_NUM    snapshot bitmaps
// commit_rat_map_table_restore   out  1                 snapshot strobe
// BEHAVIOUR
// - All RAT-side outputs registered. Reset: all outputs 0 except commit_rob_ready=1; state IDLE.
// - FSM: IDLE -> (flush_req) WALK -> (accepted entry with last) DONE -> IDLE. DONE lasts 1 cycle, flush_done=1.
// - commit_rob_ready=1 only in IDLE. Accepted lanes = valid prefix; lanes after first invalid ignored.
// - Commit: accept at N -> at N+1 lane i: commit_phy_id=new, release_phy_id=old, both valids=valid&has_rd;
//   commit_map=release_map=|valids. Strobes last exactly one cycle.
// - WALK: commit_rob_walk_ready=1; per accepted entry with has_rd, next cycle restore_new/old=entry
//   ids, restore_map=1. has_rd=0 -> consumed, no strobe. rob_walk_valid=0 -> stall in WALK.
// - flush_req with commit lanes same cycle: lanes accepted first, then WALK. flush_req outside IDLE ignored.
// - WALK with no uncommitted entries: ROB presents a single has_rd=0, last=1 entry.
// - rst mid-WALK: IDLE next cycle, pending strobes dropped, no flush_done.
// CONFIGURATION
// COMMIT_RAT_SNAPSHOT_RESTORE_EN defined:
// - Internal committed_visible[PHY_REG_NUM], reset bits 1..ARCH_REG_NUM-1 set.
// - Per accepted lane with has_rd: clear old bit, set new bit.
// - flush_req at N (snapshot includes lanes accepted at N): state RESTORE at N+1, map_table_valid=visible=
//   committed_visible, map_table_restore=1; DONE/flush_done at N+2. No walk, walk_ready stays 0, restore_map stays 0.
// Undefined: no snapshot register; map_table_* tied 0; walk as above.
// TESTING (COMMIT_WIDTH=4, ARCH_REG_NUM=32, PHY_REG_NUM=64)
// 1 rst 1 cycle -> all strobes/valids 0, commit_rob_ready=1, flush_done=0.
// 2 lanes 0,1 valid, new=32,33 old=1,2 has_rd=11 -> next cycle commit ids 32,33, release ids 1,2,
//   valids 4'b0011, both maps 1; following cycle maps 0.
// 3 lanes 0,2 valid, lane 1 invalid -> only lane 0 committed, valids 4'b0001.
// 4 flush_req, walk (40,5,rd), (x,x,no rd), (41,6,rd,last) -> restore_map pulses (40,5) then (41,6);
//   flush_done 1 cycle after last; commit_rob_ready=0 from flush_req to flush_done.
// 5 _EN defined, after test 2, flush_req -> next cycle map_table_restore=1, visible bits 32,33,3..31
//   set, 0,1,2 clear, valid==visible; flush_done next cycle; restore_map never 1.
// 6 rst while in WALK -> next cycle commit_rob_ready=1, restore_map=0, flush_done never pulses.

Source files
------------

// File: rtl/commit_rat_ctrl.sv
// Commit-side RAT driver: retires ROB head lanes into commit/release strobes and undoes speculative renames on flush.
// Optional COMMIT_RAT_SNAPSHOT_RESTORE_EN replaces the ROB walk with a one-cycle committed-snapshot restore.
module commit_rat_ctrl #(
  parameter int COMMIT_WIDTH     = 4,
  parameter int PHY_REG_NUM      = 64,
  parameter int PHY_REG_ID_WIDTH = 6,
  parameter int ARCH_REG_NUM     = 32
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [COMMIT_WIDTH-1:0]                  rob_commit_valid,
  input  logic [COMMIT_WIDTH-1:0]                  rob_commit_has_rd,
  input  logic [COMMIT_WIDTH*PHY_REG_ID_WIDTH-1:0] rob_commit_new_phy_id,
  input  logic [COMMIT_WIDTH*PHY_REG_ID_WIDTH-1:0] rob_commit_old_phy_id,
  output logic                                     commit_rob_ready,
  input  logic                                     flush_req,
  input  logic                                     rob_walk_valid,
  input  logic                                     rob_walk_has_rd,
  input  logic                                     rob_walk_last,
  input  logic [PHY_REG_ID_WIDTH-1:0]              rob_walk_new_phy_id,
  input  logic [PHY_REG_ID_WIDTH-1:0]              rob_walk_old_phy_id,
  output logic                                     commit_rob_walk_ready,
  output logic                                     flush_done,
  output logic [COMMIT_WIDTH*PHY_REG_ID_WIDTH-1:0] commit_rat_commit_phy_id,
  output logic [COMMIT_WIDTH-1:0]                  commit_rat_commit_phy_id_valid,
  output logic                                     commit_rat_commit_map,
  output logic [COMMIT_WIDTH*PHY_REG_ID_WIDTH-1:0] commit_rat_release_phy_id,
  output logic [COMMIT_WIDTH-1:0]                  commit_rat_release_phy_id_valid,
  output logic                                     commit_rat_release_map,
  output logic [PHY_REG_ID_WIDTH-1:0]              commit_rat_restore_new_phy_id,
  output logic [PHY_REG_ID_WIDTH-1:0]              commit_rat_restore_old_phy_id,
  output logic                                     commit_rat_restore_map,
  output logic [PHY_REG_NUM-1:0]                   commit_rat_map_table_valid,
  output logic [PHY_REG_NUM-1:0]                   commit_rat_map_table_visible,
  output logic                                     commit_rat_map_table_restore
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WALK    = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_RESTORE = 2'd3;

  if (ARCH_REG_NUM > PHY_REG_NUM) begin : g_cfg_check
    $error("ARCH_REG_NUM must not exceed PHY_REG_NUM");
  end

  logic [1:0]              r_state;
  logic [1:0]              w_state_next;
  logic [COMMIT_WIDTH-1:0] w_prefix;
  logic [COMMIT_WIDTH-1:0] w_lane_rd;
  logic                    w_idle;
  logic                    w_flush_accept;
  logic                    w_walk_fire;

  assign w_idle         = (r_state == S_IDLE);
  assign w_flush_accept = w_idle & flush_req;
  assign w_walk_fire    = (r_state == S_WALK) & rob_walk_valid;

  // Only the contiguous run of valid lanes starting at lane 0 retires; anything after a hole waits.
  always_comb begin
    logic w_run;
    w_run    = 1'b1;
    w_prefix = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      w_run       = w_run & rob_commit_valid[i];
      w_prefix[i] = w_run;
    end
  end

  assign w_lane_rd = w_idle ? (w_prefix & rob_commit_has_rd) : '0;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (flush_req) begin
`ifdef COMMIT_RAT_SNAPSHOT_RESTORE_EN
          w_state_next = S_RESTORE;
`else
          w_state_next = S_WALK;
`endif
        end
      end
      S_WALK:    if (w_walk_fire && rob_walk_last) w_state_next = S_DONE;
      S_RESTORE: w_state_next = S_DONE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  assign commit_rob_ready      = w_idle;
  assign commit_rob_walk_ready = (r_state == S_WALK);
  assign flush_done            = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_rat_commit_phy_id_valid  <= '0;
      commit_rat_release_phy_id_valid <= '0;
      commit_rat_commit_map           <= 1'b0;
      commit_rat_release_map          <= 1'b0;
    end else begin
      commit_rat_commit_phy_id_valid  <= w_lane_rd;
      commit_rat_release_phy_id_valid <= w_lane_rd;
      commit_rat_commit_map           <= |w_lane_rd;
      commit_rat_release_map          <= |w_lane_rd;
    end
  end

  for (genvar gi = 0; gi < COMMIT_WIDTH; gi++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst) begin
        commit_rat_commit_phy_id[gi*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH]  <= '0;
        commit_rat_release_phy_id[gi*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH] <= '0;
      end else if (w_lane_rd[gi]) begin
        commit_rat_commit_phy_id[gi*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH] <=
          rob_commit_new_phy_id[gi*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH];
        commit_rat_release_phy_id[gi*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH] <=
          rob_commit_old_phy_id[gi*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH];
      end
    end
  end

  // Walk entries without a destination are consumed silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      commit_rat_restore_map        <= 1'b0;
      commit_rat_restore_new_phy_id <= '0;
      commit_rat_restore_old_phy_id <= '0;
    end else begin
      commit_rat_restore_map <= w_walk_fire & rob_walk_has_rd;
      if (w_walk_fire && rob_walk_has_rd) begin
        commit_rat_restore_new_phy_id <= rob_walk_new_phy_id;
        commit_rat_restore_old_phy_id <= rob_walk_old_phy_id;
      end
    end
  end

`ifdef COMMIT_RAT_SNAPSHOT_RESTORE_EN
  logic [PHY_REG_NUM-1:0] r_committed_visible;
  logic [PHY_REG_NUM-1:0] w_visible_next;

  // Lanes applied in order so a later lane's mapping wins over an earlier one.
  always_comb begin
    w_visible_next = r_committed_visible;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      if (w_lane_rd[i]) begin
        w_visible_next[rob_commit_old_phy_id[i*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH]] = 1'b0;
        w_visible_next[rob_commit_new_phy_id[i*PHY_REG_ID_WIDTH +: PHY_REG_ID_WIDTH]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHY_REG_NUM; i++)
        r_committed_visible[i] <= (i >= 1) && (i < ARCH_REG_NUM);
      commit_rat_map_table_valid   <= '0;
      commit_rat_map_table_visible <= '0;
      commit_rat_map_table_restore <= 1'b0;
    end else begin
      r_committed_visible          <= w_visible_next;
      commit_rat_map_table_restore <= w_flush_accept;
      if (w_flush_accept) begin
        commit_rat_map_table_valid   <= w_visible_next;
        commit_rat_map_table_visible <= w_visible_next;
      end
    end
  end
`else
  assign commit_rat_map_table_valid   = '0;
  assign commit_rat_map_table_visible = '0;
  assign commit_rat_map_table_restore = 1'b0;
`endif

endmodule
